// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer arbiter: default widths, draw opcodes,
// FSM state encoding and the round-robin winner encoding.
package fb_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_XOR   = 2'b01,
        OP_READ  = 2'b10,
        OP_NOP   = 2'b11
    } draw_op_e;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_RMW_WR = 1'b1
    } fb_state_e;

    localparam logic WIN_SCAN = 1'b0;
    localparam logic WIN_DRAW = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: the registered last winner loses any tie;
// a lone requester always wins.
module rr_arb2
    import fb_pkg::*;
(
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic en_i,
    input  logic req_a_i,
    input  logic req_b_i,
    output logic gnt_a_o,
    output logic gnt_b_o
);

    logic last_q;
    logic last_d;

    always_comb begin
        gnt_a_o = 1'b0;
        gnt_b_o = 1'b0;
        if (en_i) begin
            if (req_a_i && req_b_i) begin
                if (last_q == WIN_DRAW) begin
                    gnt_a_o = 1'b1;
                end else begin
                    gnt_b_o = 1'b1;
                end
            end else begin
                gnt_a_o = req_a_i;
                gnt_b_o = req_b_i;
            end
        end
    end

    always_comb begin
        last_d = last_q;
        if (gnt_a_o) begin
            last_d = WIN_SCAN;
        end else if (gnt_b_o) begin
            last_d = WIN_DRAW;
        end
    end

    // Reset to draw so that the first tie after reset goes to scanout.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            last_q <= WIN_DRAW;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/fb_arbiter.sv
// Framebuffer port arbiter: shares one synchronous single-port RAM between the
// scanout reader and the draw engine (write / xor read-modify-write / read).
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | arbitrate; grant at most one requester and issue its access
// ST_RMW_WR | write back mem_rdata ^ latched wdata; no grants this cycle
module fb_arbiter
    import fb_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n_ms,

    input  logic              scan_req,
    input  logic [ADDR_W-1:0] scan_addr,
    output logic              scan_gnt,
    output logic [DATA_W-1:0] scan_rdata,
    output logic              scan_rvalid,

    input  logic              draw_req,
    input  logic [1:0]        draw_op,
    input  logic [ADDR_W-1:0] draw_addr,
    input  logic [DATA_W-1:0] draw_wdata,
    output logic              draw_gnt,
    output logic [DATA_W-1:0] draw_rdata,
    output logic              draw_rvalid,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              frame_dirty,
    input  logic              frame_ack
);

    fb_state_e         state_q, state_d;
    logic [ADDR_W-1:0] rmw_addr_q, rmw_addr_d;
    logic [DATA_W-1:0] rmw_wdata_q, rmw_wdata_d;
    logic              scan_pend_q, scan_pend_d;
    logic              draw_pend_q, draw_pend_d;
    logic [DATA_W-1:0] scan_rdata_q;
    logic [DATA_W-1:0] draw_rdata_q;
    logic              dirty_q, dirty_d;
    logic              arb_en;
    draw_op_e          op;

    assign op     = draw_op_e'(draw_op);
    assign arb_en = sys_rst_n_ms && (state_q == ST_IDLE);

    rr_arb2 u_rr_arb2 (
        .clk_i   (sys_clk),
        .rst_n_i (sys_rst_n_ms),
        .en_i    (arb_en),
        .req_a_i (scan_req),
        .req_b_i (draw_req),
        .gnt_a_o (scan_gnt),
        .gnt_b_o (draw_gnt)
    );

    always_comb begin
        state_d     = state_q;
        rmw_addr_d  = rmw_addr_q;
        rmw_wdata_d = rmw_wdata_q;
        scan_pend_d = 1'b0;
        draw_pend_d = 1'b0;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_wdata   = '0;
        // Reset gates the RAM strobes combinationally so an aborted RMW never writes.
        if (sys_rst_n_ms) begin
            case (state_q)
                ST_IDLE: begin
                    if (scan_gnt) begin
                        mem_en      = 1'b1;
                        mem_addr    = scan_addr;
                        scan_pend_d = 1'b1;
                    end else if (draw_gnt) begin
                        mem_addr = draw_addr;
                        case (op)
                            OP_WRITE: begin
                                mem_en    = 1'b1;
                                mem_we    = 1'b1;
                                mem_wdata = draw_wdata;
                            end
                            OP_XOR: begin
                                mem_en      = 1'b1;
                                rmw_addr_d  = draw_addr;
                                rmw_wdata_d = draw_wdata;
                                state_d     = ST_RMW_WR;
                            end
                            OP_READ: begin
                                mem_en      = 1'b1;
                                draw_pend_d = 1'b1;
                            end
                            default: begin
                                mem_en = 1'b0;
                            end
                        endcase
                    end
                end
                ST_RMW_WR: begin
                    mem_en    = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = rmw_addr_q;
                    mem_wdata = mem_rdata ^ rmw_wdata_q;
                    state_d   = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // A write in the same cycle as an ack wins, so that frame still gets refreshed.
    always_comb begin
        dirty_d = dirty_q;
        if (mem_we) begin
            dirty_d = 1'b1;
        end else if (frame_ack) begin
            dirty_d = 1'b0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n_ms) begin
            state_q      <= ST_IDLE;
            rmw_addr_q   <= '0;
            rmw_wdata_q  <= '0;
            scan_pend_q  <= 1'b0;
            draw_pend_q  <= 1'b0;
            scan_rdata_q <= '0;
            draw_rdata_q <= '0;
            dirty_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            rmw_addr_q   <= rmw_addr_d;
            rmw_wdata_q  <= rmw_wdata_d;
            scan_pend_q  <= scan_pend_d;
            draw_pend_q  <= draw_pend_d;
            scan_rdata_q <= scan_rdata;
            draw_rdata_q <= draw_rdata;
            dirty_q      <= dirty_d;
        end
    end

    // RAM data arrives one cycle after the grant; pass it through while valid, hold otherwise.
    assign scan_rvalid = scan_pend_q;
    assign draw_rvalid = draw_pend_q;
    assign scan_rdata  = scan_pend_q ? mem_rdata : scan_rdata_q;
    assign draw_rdata  = draw_pend_q ? mem_rdata : draw_rdata_q;
    assign frame_dirty = dirty_q;

endmodule
